// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at pc, holds it until the consumer
// accepts, then redirects pc (sequential, branch, jump or register jump).
module instr_fetch #(
  parameter logic [0:31] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [0:31] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [0:31] imem_data,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic [0:31] branch_offset,
  input  logic        jump,
  input  logic [0:31] jump_offset,
  input  logic        jump_reg,
  input  logic [0:31] jump_target,
  output logic [0:31] instr,
  output logic        instr_valid,
  output logic [0:15] imm16,
  output logic [0:25] imm26,
  output logic        ext_sign,
  output logic [0:31] pc,
  output logic [0:31] retired,
  output logic        fault
);

  typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;

  state_t      state;
  logic [0:31] pc_q, instr_q, retired_q;
  logic        fault_q;
  logic [0:31] seq_pc, next_pc;

  always_comb begin
    seq_pc = pc_q + 32'd4;
    if (jump_reg)          next_pc = jump_target;
    else if (jump)         next_pc = seq_pc + jump_offset;
    else if (branch_taken) next_pc = seq_pc + branch_offset;
    else                   next_pc = seq_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          instr_q <= imem_data;
          state   <= VALID;
        end
        VALID: if (instr_accept) begin
          retired_q <= retired_q + 32'd1;
          // A misaligned target retires the instruction but freezes pc.
          if (next_pc[30:31] != 2'b00) begin
            fault_q <= 1'b1;
            state   <= HALT;
          end else begin
            pc_q  <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  // Request is masked by reset so nothing is issued during a held reset.
  assign imem_req    = (state == FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state == VALID);
  assign instr       = instr_q;
  assign imm16       = instr_q[16:31];
  assign imm26       = instr_q[6:31];
  // Opcodes 0x0C..0x0F (logical immediates) take zero extension.
  assign ext_sign    = (instr_q[0:3] != 4'b0011);
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign fault       = fault_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, PC loaded at reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high.
REQ-004 SHALL have port: imem_addr  output  [0:31]  fetch address, bit 0 = MSB.
REQ-005 SHALL have port: imem_req  output  1  fetch request.
REQ-006 SHALL have port: imem_ready  input  1  imem_data valid this cycle.
REQ-007 SHALL have port: imem_data  input  [0:31]  fetched instruction word.
REQ-008 SHALL have port: instr_accept  input  1  consumer takes current instruction.
REQ-009 SHALL have ports: branch_taken  input  1; branch_offset  input  [0:31]  sign-extended 16-bit byte offset.
REQ-010 SHALL have ports: jump  input  1; jump_offset  input  [0:31]  extended 26-bit byte offset.
REQ-011 SHALL have ports: jump_reg  input  1; jump_target  input  [0:31]  absolute register target.
REQ-012 SHALL have port: instr  output  [0:31]  held instruction.
REQ-013 SHALL have port: instr_valid  output  1  instr holds an unaccepted instruction.
REQ-014 SHALL have ports: imm16  output  [0:15] = instr[16:31]; imm26  output  [0:25] = instr[6:31].
REQ-015 SHALL have port: ext_sign  output  1  sign/zero select for downstream 16- and 26-bit extenders.
REQ-016 SHALL have ports: pc  output  [0:31]  address of held instruction; retired  output  [0:31]  accepted-instruction count.
REQ-017 SHALL have port: fault  output  1  sticky misaligned-target flag.

Function
REQ-018 SHALL implement FSM states FETCH, VALID, HALT.
REQ-019 FETCH: imem_req=1, imem_addr=pc; on imem_ready, SHALL latch imem_data into instr and move to VALID next edge.
REQ-020 Latency: imem_ready high in cycle n -> instr_valid high in cycle n+1; minimum two cycles per instruction.
REQ-021 VALID: instr_valid=1, imem_req=0; instr SHALL hold stable until instr_accept.
REQ-022 On instr_accept in VALID, next pc SHALL be chosen by priority: jump_reg -> jump_target; else jump -> pc+4+jump_offset; else branch_taken -> pc+4+branch_offset; else pc+4.
REQ-023 branch_taken, jump, jump_reg and offsets SHALL be sampled only in the accept cycle; ignored otherwise.
REQ-024 All PC arithmetic SHALL be unsigned 32-bit, modulo 2^32 (pc 32'hFFFFFFFC + 4 -> 32'h00000000).
REQ-025 On accept, retired SHALL increment by 1, wrapping 32'hFFFFFFFF -> 0.
REQ-026 If the selected next pc has bits [30:31] != 2'b00, SHALL enter HALT, set fault=1, leave pc unchanged, still increment retired.
REQ-027 HALT: imem_req=0, instr_valid=0; exited only by reset.
REQ-028 ext_sign SHALL be 0 when instr[0:5] is 6'h0C, 6'h0D, 6'h0E or 6'h0F; 1 otherwise.
REQ-029 imem_ready or instr_accept outside their owning state SHALL be ignored.
REQ-030 instr_accept with imem_ready in the same cycle in VALID SHALL act as accept only.

Reset
REQ-031 With reset high at an edge, SHALL set pc=RESET_PC, instr=0, instr_valid=0, retired=0, fault=0, state=FETCH.
REQ-032 imem_req SHALL be 0 while reset is high; first request in the cycle after reset drops.
REQ-033 Reset SHALL take priority over imem_ready and instr_accept in the same cycle; an in-flight fetch is abandoned and reissued at RESET_PC.

Verification
REQ-034 Reset, imem_ready high one cycle after req with data 32'h20010005 -> next cycle instr_valid=1, imm16=16'h0005, ext_sign=1, pc=0.
REQ-035 Data 32'h34010005 (opcode 6'h0D) -> ext_sign=0.
REQ-036 pc=32'h00000100, accept with branch_taken=1, branch_offset=32'hFFFFFFF8 -> next pc=32'h000000FC, retired+1.
REQ-037 Accept with jump=1, jump_reg=1, jump_target=32'h00000400, branch_taken=1 -> next pc=32'h00000400.
REQ-038 Accept with jump_reg=1, jump_target=32'h00000402 -> fault=1, state HALT, imem_req=0 until reset.
REQ-039 Reset asserted in FETCH coincident with imem_ready -> instr_valid stays 0, next request at RESET_PC, retired=0.
